// File: rtl/circle_raster_pkg.sv
// Shared types and default geometry for the circle rasteriser.
package circle_raster_pkg;

   localparam int DEF_H_RES = 640;
   localparam int DEF_V_RES = 480;
   localparam int DEF_RW    = 10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INIT = 3'd1,
      ST_EMIT = 3'd2,
      ST_STEP = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

endpackage

// File: rtl/circle_addr_calc.sv
// Clips a signed candidate coordinate to the screen and forms the linear
// frame-buffer address row*H_RES+col.
module circle_addr_calc
   import circle_raster_pkg::*;
#(
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES,
   parameter int XW    = $clog2(H_RES),
   parameter int YW    = $clog2(V_RES),
   parameter int AW    = $clog2(H_RES*V_RES)
)(
   input  logic signed [XW:0]   col,
   input  logic signed [YW:0]   row,
   output logic                 in_range,
   output logic [AW-1:0]        addr
);

   logic col_ok_s;
   logic row_ok_s;

   // The sign bit rejects negatives; the magnitude test rejects the far edges.
   assign col_ok_s = !col[XW] && ($unsigned(col) < (XW+1)'(H_RES));
   assign row_ok_s = !row[YW] && ($unsigned(row) < (YW+1)'(V_RES));
   assign in_range = col_ok_s && row_ok_s;

   assign addr = AW'(row[YW-1:0]) * AW'(H_RES) + AW'(col[XW-1:0]);

endmodule

// File: rtl/circle_raster.sv
// Midpoint circle rasteriser: walks one octant and emits one outline
// candidate or one fill-span pixel per cycle, with downstream back-pressure.
module circle_raster
   import circle_raster_pkg::*;
#(
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES,
   parameter int RW    = DEF_RW,
   localparam int XW   = $clog2(H_RES),
   localparam int YW   = $clog2(V_RES),
   localparam int AW   = $clog2(H_RES*V_RES)
)(
   input  logic           clk,
   input  logic           n_rst,
   input  logic           start,
   input  logic [XW-1:0]  center_x,
   input  logic [YW-1:0]  center_y,
   input  logic [RW-1:0]  radius,
   input  logic           fill,
   input  logic           stall,
   output logic           pix_valid,
   output logic [AW-1:0]  pix_addr,
   output logic           busy,
   output logic           done
);

   localparam int DW  = RW + 3;
   localparam int CXW = XW + 1;
   localparam int CYW = YW + 1;
   localparam int KW  = RW + 1;

   localparam logic signed [DW-1:0] D_THREE = DW'(3);
   localparam logic signed [DW-1:0] D_SIX   = DW'(6);
   localparam logic signed [DW-1:0] D_TEN   = DW'(10);

   state_t                 state_r, state_s;
   logic [XW-1:0]          cx_r;
   logic [YW-1:0]          cy_r;
   logic [RW-1:0]          rad_r;
   logic                   fill_r;
   logic [RW-1:0]          x_r, y_r;
   logic signed [DW-1:0]   d_r;
   logic [2:0]             seg_r;
   logic [KW-1:0]          k_r;
   logic                   pix_valid_r;
   logic [AW-1:0]          pix_addr_r;
   logic                   busy_r;
   logic                   done_r;

   logic signed [CXW-1:0]  cxs_s, xc_s, yc_s, col_s;
   logic signed [CYW-1:0]  cys_s, xr_s, yr_s, row_s;
   logic [RW-1:0]          half_s;
   logic                   span_end_s, last_s, rad_zero_s;
   logic signed [DW-1:0]   xe_s, ye_s, d_next_s;
   logic [RW-1:0]          x_next_s, y_next_s;
   logic                   loop_s;
   logic                   cand_ok_s;
   logic [AW-1:0]          cand_addr_s;

   assign cxs_s = $signed({1'b0, cx_r});
   assign cys_s = $signed({1'b0, cy_r});
   assign xc_s  = $signed(CXW'(x_r));
   assign yc_s  = $signed(CXW'(y_r));
   assign xr_s  = $signed(CYW'(x_r));
   assign yr_s  = $signed(CYW'(y_r));
   assign xe_s  = $signed({3'b000, x_r});
   assign ye_s  = $signed({3'b000, y_r});

   // Fill spans 0/1 are x wide (rows cy+-y), spans 2/3 are y wide (rows cy+-x).
   assign half_s     = seg_r[1] ? y_r : x_r;
   assign span_end_s = (k_r == {half_s, 1'b0});
   assign rad_zero_s = (rad_r == {RW{1'b0}});
   assign last_s     = fill_r ? ((seg_r == 3'd3) && span_end_s) : (seg_r == 3'd7);

   // Candidate coordinate for the current EMIT cycle.
   always_comb begin
      col_s = cxs_s;
      row_s = cys_s;
      if (fill_r) begin
         col_s = cxs_s - $signed(CXW'(half_s)) + $signed(CXW'(k_r));
         case (seg_r)
            3'd0:    row_s = cys_s + yr_s;
            3'd1:    row_s = cys_s - yr_s;
            3'd2:    row_s = cys_s + xr_s;
            3'd3:    row_s = cys_s - xr_s;
            default: row_s = cys_s;
         endcase
      end else begin
         case (seg_r)
            3'd0:    begin col_s = cxs_s + xc_s; row_s = cys_s + yr_s; end
            3'd1:    begin col_s = cxs_s - xc_s; row_s = cys_s + yr_s; end
            3'd2:    begin col_s = cxs_s + xc_s; row_s = cys_s - yr_s; end
            3'd3:    begin col_s = cxs_s - xc_s; row_s = cys_s - yr_s; end
            3'd4:    begin col_s = cxs_s + yc_s; row_s = cys_s + xr_s; end
            3'd5:    begin col_s = cxs_s - yc_s; row_s = cys_s + xr_s; end
            3'd6:    begin col_s = cxs_s + yc_s; row_s = cys_s - xr_s; end
            3'd7:    begin col_s = cxs_s - yc_s; row_s = cys_s - xr_s; end
            default: begin col_s = cxs_s;        row_s = cys_s;        end
         endcase
      end
   end

   // Midpoint decision update for the STEP state.
   assign d_next_s = d_r[DW-1] ? (d_r + (xe_s <<< 2) + D_SIX)
                               : (d_r + ((xe_s - ye_s) <<< 2) + D_TEN);
   assign y_next_s = d_r[DW-1] ? y_r : (y_r - RW'(1));
   assign x_next_s = x_r + RW'(1);
   assign loop_s   = (x_next_s <= y_next_s);

   circle_addr_calc #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .XW    (XW),
      .YW    (YW),
      .AW    (AW)
   ) u_addr_calc (
      .col      (col_s),
      .row      (row_s),
      .in_range (cand_ok_s),
      .addr     (cand_addr_s)
   );

   // Next-state logic; a stalled cycle holds the current state.
   always_comb begin
      state_s = state_r;
      if (stall) begin
         state_s = state_r;
      end else begin
         case (state_r)
            ST_IDLE: if (start) state_s = ST_INIT; else state_s = ST_IDLE;
            ST_INIT: state_s = ST_EMIT;
            ST_EMIT: begin
               // A zero radius is a single centre pixel; skip the octant walk.
               if (rad_zero_s)  state_s = ST_FIN;
               else if (last_s) state_s = ST_STEP;
               else             state_s = ST_EMIT;
            end
            ST_STEP: if (loop_s) state_s = ST_EMIT; else state_s = ST_FIN;
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Datapath, counters and registered outputs; all frozen while stalled.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cx_r        <= {XW{1'b0}};
         cy_r        <= {YW{1'b0}};
         rad_r       <= {RW{1'b0}};
         fill_r      <= 1'b0;
         x_r         <= {RW{1'b0}};
         y_r         <= {RW{1'b0}};
         d_r         <= {DW{1'b0}};
         seg_r       <= 3'd0;
         k_r         <= {KW{1'b0}};
         pix_valid_r <= 1'b0;
         pix_addr_r  <= {AW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else if (!stall) begin
         pix_valid_r <= 1'b0;
         done_r      <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  cx_r   <= center_x;
                  cy_r   <= center_y;
                  rad_r  <= radius;
                  fill_r <= fill;
                  busy_r <= 1'b1;
               end
            end
            ST_INIT: begin
               x_r   <= {RW{1'b0}};
               y_r   <= rad_r;
               d_r   <= D_THREE - $signed({2'b00, rad_r, 1'b0});
               seg_r <= 3'd0;
               k_r   <= {KW{1'b0}};
            end
            ST_EMIT: begin
               pix_valid_r <= cand_ok_s;
               if (cand_ok_s) pix_addr_r <= cand_addr_s;
               if (fill_r && !span_end_s) begin
                  k_r <= k_r + KW'(1);
               end else begin
                  k_r   <= {KW{1'b0}};
                  seg_r <= seg_r + 3'd1;
               end
            end
            ST_STEP: begin
               d_r   <= d_next_s;
               y_r   <= y_next_s;
               x_r   <= x_next_s;
               seg_r <= 3'd0;
               k_r   <= {KW{1'b0}};
            end
            ST_FIN: begin
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign pix_valid = pix_valid_r;
   assign pix_addr  = pix_addr_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule
